uart_word_assembler: RTL and testbench

- Sits directly downstream of the UART receiver.
- Collects consecutive received bytes (pulsed by the receiver's rx_done_tick with dout) into a WBYTES-wide operand word, least-significant byte first, and presents it to the CORDIC command path with a valid/ready handshake.
- Double-buffered: the next word assembles while the previous one waits.
- An inter-byte timeout, counted in baud oversampling ticks, discards partial words so the link resynchronises after a dropped byte.

---
 rtl/uart_word_assembler.sv | 112 +++++++++++
 tb/tb_uart_word_assembler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/uart_word_assembler.sv
// Packs UART bytes LSB-first into WBYTES words behind a one-deep output buffer; word appears 1 clk after its last byte.
// Assembly never stalls: a completed word that finds the buffer occupied is dropped with an overrun pulse.
module uart_word_assembler #(
    parameter int WBYTES        = 4,
    parameter int TIMEOUT_TICKS = 640,
    parameter int TW            = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s_tick,
    input  logic                  rx_done_tick,
    input  logic [7:0]            din,
    output logic [8*WBYTES-1:0]   word_out,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic                  overrun_tick,
    output logic                  timeout_tick,
    output logic [2:0]            byte_cnt
);

    typedef enum logic {IDLE, ASSEMBLE} state_t;

    localparam logic [2:0]    LAST_LANE = 3'(WBYTES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_TICKS - 1);

    state_t               state_q;
    logic [2:0]           byte_cnt_q;
    logic [8*WBYTES-1:0]  asm_q;
    logic [8*WBYTES-1:0]  asm_d;
    logic [8*WBYTES-1:0]  word_q;
    logic                 valid_q;
    logic                 ovr_q;
    logic                 tmo_q;
    logic [TW-1:0]        cnt_q;

    // Assembly register with din merged into the current lane; on the last lane this is the finished word.
    always_comb begin
        asm_d = asm_q;
        for (int i = 0; i < WBYTES; i++) begin
            if (byte_cnt_q == 3'(i)) begin
                asm_d[8*i +: 8] = din;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            ovr_q      <= 1'b0;
            tmo_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ovr_q <= 1'b0;
            tmo_q <= 1'b0;
            if (valid_q && word_ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_done_tick) begin
                        asm_q      <= asm_d;
                        byte_cnt_q <= 3'd1;
                        state_q    <= ASSEMBLE;
                    end
                end
                ASSEMBLE: begin
                    if (rx_done_tick) begin
                        cnt_q <= '0;
                        if (byte_cnt_q == LAST_LANE) begin
                            // A same-cycle consume frees the buffer, so the new word takes its place.
                            if (!valid_q || word_ready) begin
                                word_q  <= asm_d;
                                valid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                            asm_q      <= '0;
                            byte_cnt_q <= '0;
                            state_q    <= IDLE;
                        end else begin
                            asm_q      <= asm_d;
                            byte_cnt_q <= byte_cnt_q + 3'd1;
                        end
                    end else if (s_tick) begin
                        if (cnt_q == TMO_LAST) begin
                            tmo_q      <= 1'b1;
                            asm_q      <= '0;
                            byte_cnt_q <= '0;
                            cnt_q      <= '0;
                            state_q    <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign word_out     = word_q;
    assign word_valid   = valid_q;
    assign overrun_tick = ovr_q;
    assign timeout_tick = tmo_q;
    assign byte_cnt     = byte_cnt_q;

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler: words expected at the output are queued when their last byte is driven.
module tb_uart_word_assembler;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_tick;
    logic        rx_done_tick;
    logic [7:0]  din;
    logic [31:0] word_out;
    logic        word_valid;
    logic        word_ready;
    logic        overrun_tick;
    logic        timeout_tick;
    logic [2:0]  byte_cnt;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    uart_word_assembler #(.WBYTES(4), .TIMEOUT_TICKS(640), .TW(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .overrun_tick (overrun_tick),
        .timeout_tick (timeout_tick),
        .byte_cnt     (byte_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after posedge, so the falling edge sees exactly what the next posedge will sample.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", word_out, 64'hDEAD);
            end else begin
                check("scoreboard_word", word_out, exp_q.pop_front());
            end
        end
    end

    task automatic cycle(input logic tick);
        s_tick = tick;
        @(posedge clk);
        #1;
        s_tick = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic tick);
        rx_done_tick = 1'b1;
        din          = b;
        s_tick       = tick;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        s_tick       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; s_tick = 1'b0; rx_done_tick = 1'b0; din = 8'h00; word_ready = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", word_valid, 1'b0);
        check("rst_word", word_out, 32'h0);
        check("rst_cnt", byte_cnt, 3'd0);
        check("rst_ticks", {overrun_tick, timeout_tick}, 2'b00);
        reset = 1'b0;
        cycle(1'b0);

        // Basic assembly, held with word_ready low
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        check("cnt_after_3", byte_cnt, 3'd3);
        check("valid_before_last", word_valid, 1'b0);
        exp_q.push_back(32'h44332211);
        send_byte(8'h44, 1'b0);
        check("valid_latency", word_valid, 1'b1);
        check("word1", word_out, 32'h44332211);
        check("cnt_after_word", byte_cnt, 3'd0);
        repeat (3) cycle(1'b0);
        check("word1_hold", word_out, 32'h44332211);
        check("valid_hold", word_valid, 1'b1);

        // Overrun while the first word is still held
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        send_byte(8'hDD, 1'b0);
        check("overrun_pulse", overrun_tick, 1'b1);
        check("overrun_word_kept", word_out, 32'h44332211);
        check("overrun_cnt", byte_cnt, 3'd0);
        cycle(1'b0);
        check("overrun_one_cycle", overrun_tick, 1'b0);

        // Same-cycle handoff: consume and load on the same edge
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        exp_q.push_back(32'hDDCCBBAA);
        word_ready = 1'b1;
        send_byte(8'hDD, 1'b0);
        word_ready = 1'b0;
        check("handoff_no_overrun", overrun_tick, 1'b0);
        check("handoff_valid", word_valid, 1'b1);
        check("handoff_word", word_out, 32'hDDCCBBAA);
        word_ready = 1'b1;
        cycle(1'b0);
        word_ready = 1'b0;
        check("valid_clears", word_valid, 1'b0);

        // Inter-byte timeout
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        for (int i = 0; i < 639; i++) begin
            cycle(1'b1);
            cycle(1'b0);
        end
        check("no_timeout_639", timeout_tick, 1'b0);
        check("cnt_before_timeout", byte_cnt, 3'd2);
        cycle(1'b1);
        check("timeout_pulse", timeout_tick, 1'b1);
        check("timeout_cnt", byte_cnt, 3'd0);
        cycle(1'b0);
        check("timeout_one_cycle", timeout_tick, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        exp_q.push_back(32'h40302010);
        send_byte(8'h40, 1'b0);
        check("post_timeout_word", word_out, 32'h40302010);
        word_ready = 1'b1;
        cycle(1'b0);
        word_ready = 1'b0;

        // Byte coinciding with the 640th tick wins and restarts the count
        send_byte(8'h05, 1'b0);
        repeat (639) cycle(1'b1);
        send_byte(8'h06, 1'b1);
        check("tie_no_timeout", timeout_tick, 1'b0);
        check("tie_cnt", byte_cnt, 3'd2);
        repeat (639) cycle(1'b1);
        check("tie_restart_no_timeout", timeout_tick, 1'b0);
        cycle(1'b1);
        check("tie_restart_timeout", timeout_tick, 1'b1);
        check("tie_restart_cnt", byte_cnt, 3'd0);

        // Asynchronous reset with a word pending and a partial word in flight
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        send_byte(8'h99, 1'b0);
        send_byte(8'hAB, 1'b0);
        check("pre_reset_valid", word_valid, 1'b1);
        check("pre_reset_cnt", byte_cnt, 3'd2);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", word_valid, 1'b0);
        check("async_rst_word", word_out, 32'h0);
        check("async_rst_cnt", byte_cnt, 3'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cycle(1'b0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
